// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin grant controller.
package rr_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_GRANT} rr_state_t;

  // Upper bound on requester count supported by the mask helper.
  localparam int unsigned MAX_REQ = 64;

  typedef logic [MAX_REQ-1:0] req_vec_t;

  // Mask with bits ptr..width-1 set: requesters at or above the pointer.
  function automatic req_vec_t wrap_mask(input int unsigned ptr, input int unsigned width);
    req_vec_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if ((i >= ptr) && (i < width)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/first1_finder.sv
// Lowest set bit search: one-hot result, binary index and found flag.
module first1_finder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [WIDTH-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found_o  = 1'b0;
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (vec_i[i-1]) begin
        onehot_o = '0;
        onehot_o[i-1] = 1'b1;
        idx_o    = IDX_W'(i-1);
        found_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin arbiter with registered valid/ack handshake and grant lock.
module rr_grant_ctrl
  import rr_pkg::*;
#(
  parameter int unsigned REQ_CNT = 4,
  parameter int unsigned IDX_W   = $clog2(REQ_CNT)
) (
  input  logic               clk_i,
  input  logic               srst_n_i,
  input  logic [REQ_CNT-1:0] req_i,
  input  logic               lock_i,
  input  logic               grant_ack_i,
  output logic               grant_val_o,
  output logic [REQ_CNT-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               busy_o
);

  rr_state_t          state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;

  logic [REQ_CNT-1:0] masked;
  logic [REQ_CNT-1:0] m_onehot, r_onehot, sel_onehot;
  logic [IDX_W-1:0]   m_idx, r_idx, sel_idx;
  logic               m_found, r_found;

  assign masked = req_i & REQ_CNT'(wrap_mask(32'(ptr), REQ_CNT));

  first1_finder #(.WIDTH(REQ_CNT), .IDX_W(IDX_W)) u_find_masked (
    .vec_i    (masked),
    .onehot_o (m_onehot),
    .idx_o    (m_idx),
    .found_o  (m_found)
  );

  first1_finder #(.WIDTH(REQ_CNT), .IDX_W(IDX_W)) u_find_raw (
    .vec_i    (req_i),
    .onehot_o (r_onehot),
    .idx_o    (r_idx),
    .found_o  (r_found)
  );

  // Prefer requesters at/above the pointer; otherwise wrap to the lowest one.
  always_comb begin
    sel_onehot = r_onehot;
    sel_idx    = r_idx;
    if (m_found) begin
      sel_onehot = m_onehot;
      sel_idx    = m_idx;
    end
  end

  // Explicit wrap keeps the pointer in range for non-power-of-two counts.
  always_comb begin
    ptr_next = grant_idx_o + IDX_W'(1);
    if (grant_idx_o == IDX_W'(REQ_CNT - 1)) ptr_next = '0;
  end

  // Grant FSM, rotation pointer and registered grant outputs.
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      grant_val_o <= 1'b0;
      grant_o     <= '0;
      grant_idx_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (r_found) begin
            state       <= ST_GRANT;
            grant_val_o <= 1'b1;
            grant_o     <= sel_onehot;
            grant_idx_o <= sel_idx;
          end
        end
        ST_GRANT: begin
          if (grant_ack_i && !lock_i) begin
            state       <= ST_IDLE;
            ptr         <= ptr_next;
            grant_val_o <= 1'b0;
            grant_o     <= '0;
            grant_idx_o <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Directed bench for rr_grant_ctrl (REQ_CNT=4 and REQ_CNT=3 instances).
module tb_rr_grant_ctrl;

  logic       clk = 1'b0;
  logic       srst_n;

  logic [3:0] req_a;
  logic       lock_a, ack_a;
  logic       gv_a, busy_a;
  logic [3:0] g_a;
  logic [1:0] gi_a;

  logic [2:0] req_b;
  logic       lock_b, ack_b;
  logic       gv_b, busy_b;
  logic [2:0] g_b;
  logic [1:0] gi_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_ctrl #(.REQ_CNT(4)) dut_a (
    .clk_i       (clk),
    .srst_n_i    (srst_n),
    .req_i       (req_a),
    .lock_i      (lock_a),
    .grant_ack_i (ack_a),
    .grant_val_o (gv_a),
    .grant_o     (g_a),
    .grant_idx_o (gi_a),
    .busy_o      (busy_a)
  );

  rr_grant_ctrl #(.REQ_CNT(3)) dut_b (
    .clk_i       (clk),
    .srst_n_i    (srst_n),
    .req_i       (req_b),
    .lock_i      (lock_b),
    .grant_ack_i (ack_b),
    .grant_val_o (gv_b),
    .grant_o     (g_b),
    .grant_idx_o (gi_b),
    .busy_o      (busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_grant(input string tag, input int k);
    check({tag, " val"},  32'(gv_a),   32'd1);
    check({tag, " oh"},   32'(g_a),    32'(1) << k);
    check({tag, " idx"},  32'(gi_a),   32'(k));
    check({tag, " busy"}, 32'(busy_a), 32'd1);
  endtask

  task automatic a_idle(input string tag);
    check({tag, " val"},  32'(gv_a),   32'd0);
    check({tag, " oh"},   32'(g_a),    32'd0);
    check({tag, " idx"},  32'(gi_a),   32'd0);
    check({tag, " busy"}, 32'(busy_a), 32'd0);
  endtask

  task automatic b_grant(input string tag, input int k);
    check({tag, " val"}, 32'(gv_b), 32'd1);
    check({tag, " oh"},  32'(g_b),  32'(1) << k);
    check({tag, " idx"}, 32'(gi_b), 32'(k));
  endtask

  initial begin
    int seq_a[4] = '{1, 2, 3, 0};
    int seq_b[3] = '{1, 2, 0};

    srst_n = 1'b0;
    req_a = '0; lock_a = 1'b0; ack_a = 1'b0;
    req_b = '0; lock_b = 1'b0; ack_b = 1'b0;
    step();
    step();
    a_idle("reset");
    srst_n = 1'b1;

    // No requests; ack/lock toggling in IDLE must have no effect.
    for (int i = 0; i < 5; i++) begin
      ack_a  = i[0];
      lock_a = i[1];
      step();
      a_idle("idle");
    end
    ack_a = 1'b0; lock_a = 1'b0;

    // All requesting, unlocked acks: 0,1,2,3,0 with one bubble each.
    req_a = 4'b1111;
    step();
    a_grant("rr0", 0);
    for (int i = 0; i < 4; i++) begin
      ack_a = 1'b1;
      step();
      ack_a = 1'b0;
      a_idle("bubble");
      step();
      a_grant("rr", seq_a[i]);
    end

    // ptr=1 now; grant 1 alone, then ptr=2 and req 0011 wraps to 0.
    ack_a = 1'b1; req_a = 4'b0010;
    step(); ack_a = 1'b0; a_idle("bub1");
    step(); a_grant("g1", 1);
    ack_a = 1'b1; req_a = 4'b0011;
    step(); ack_a = 1'b0; a_idle("bub2");
    step(); a_grant("wrap", 0);
    // ptr=1 after granting 0: full request picks 1.
    ack_a = 1'b1; req_a = 4'b1111;
    step(); ack_a = 1'b0; a_idle("bub3");
    step(); a_grant("ptr1", 1);

    // Locked beats keep grant 1.
    ack_a = 1'b1; lock_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      a_grant("lock", 1);
    end
    lock_a = 1'b0;
    step(); ack_a = 1'b0; a_idle("unlock");
    step(); a_grant("after", 2);

    // No ack while requests change: grant held.
    req_a = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      step();
      a_grant("hold", 2);
    end

    // Reset mid-grant, then ptr back at 0.
    srst_n = 1'b0;
    step();
    a_idle("midrst");
    srst_n = 1'b1; req_a = 4'b0110;
    step();
    a_grant("postrst", 1);

    // Three requesters: 0,1,2,0.
    req_b = 3'b111;
    step();
    b_grant("b0", 0);
    for (int i = 0; i < 3; i++) begin
      ack_b = 1'b1;
      step();
      ack_b = 1'b0;
      check("b bubble", 32'(gv_b), 32'd0);
      step();
      b_grant("b", seq_b[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
